// File: rtl/life_grid_engine_if.sv
// Host/display side of the Game-of-Life engine: rule masks, row load/readback, run control and status.
interface life_grid_engine_if #(
  parameter int WIDTH  = 16,
  parameter int HEIGHT = 16,
  parameter int GEN_W  = 16
) ();
  localparam int RW = $clog2(HEIGHT);

  logic [8:0]       birth_mask;
  logic [8:0]       survive_mask;
  logic             wr_en;
  logic [RW-1:0]    wr_row;
  logic [WIDTH-1:0] wr_data;
  logic             clr;
  logic [RW-1:0]    rd_row;
  logic [WIDTH-1:0] rd_data;
  logic             start;
  logic [GEN_W-1:0] gens;
  logic             busy;
  logic             done;
  logic             stable;
  logic [GEN_W-1:0] gen_count;

  modport master (
    output birth_mask, survive_mask, wr_en, wr_row, wr_data, clr, rd_row, start, gens,
    input  rd_data, busy, done, stable, gen_count
  );

  modport slave (
    input  birth_mask, survive_mask, wr_en, wr_row, wr_data, clr, rd_row, start, gens,
    output rd_data, busy, done, stable, gen_count
  );
endinterface

// File: rtl/life_grid_engine.sv
// Game-of-Life engine: one next-state row per clock into a shadow buffer, committed once per generation
// (HEIGHT+1 cycles/gen, rd_data 1 cycle); wr_en/clr/start outside IDLE are dropped, not queued.
module life_grid_engine #(
  parameter int WIDTH  = 16,
  parameter int HEIGHT = 16,
  parameter bit WRAP   = 1'b1,
  parameter int GEN_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  life_grid_engine_if.slave bus
);
  localparam int            RW   = $clog2(HEIGHT);
  localparam logic [RW-1:0] LAST = RW'(HEIGHT - 1);
  localparam logic [RW:0]   ROWS = (RW + 1)'(HEIGHT);

  typedef enum logic [1:0] {IDLE, STEP, COMMIT, DONE} state_t;
  state_t state, state_nxt;

  logic [WIDTH-1:0] grid   [HEIGHT];
  logic [WIDTH-1:0] shadow [HEIGHT];
  logic [RW-1:0]    row;
  logic [GEN_W-1:0] remaining;
  logic [8:0]       birth;
  logic [8:0]       survive;
  logic [WIDTH-1:0] up, cur, dn, nxt_row;
  logic [WIDTH-1:0] nb [8];
  logic [3:0]       cnt;
  logic             same;

  // Bit c of the result is the neighbour at column c-1 (from_left) or c+1 (from_right).
  function automatic logic [WIDTH-1:0] from_left(input logic [WIDTH-1:0] v);
    return {v[WIDTH-2:0], v[WIDTH-1] & WRAP};
  endfunction

  function automatic logic [WIDTH-1:0] from_right(input logic [WIDTH-1:0] v);
    return {v[0] & WRAP, v[WIDTH-1:1]};
  endfunction

  always_comb begin
    cur = grid[row];
    up  = '0;
    dn  = '0;
    if (row != '0) up = grid[row - 1'b1];
    else if (WRAP) up = grid[LAST];
    if (row != LAST) dn = grid[row + 1'b1];
    else if (WRAP) dn = grid[0];
  end

  always_comb begin
    nb[0] = from_left(up);
    nb[1] = up;
    nb[2] = from_right(up);
    nb[3] = from_left(cur);
    nb[4] = from_right(cur);
    nb[5] = from_left(dn);
    nb[6] = dn;
    nb[7] = from_right(dn);
    nxt_row = '0;
    cnt     = '0;
    for (int c = 0; c < WIDTH; c++) begin
      cnt = '0;
      for (int k = 0; k < 8; k++) cnt = cnt + {3'b000, nb[k][c]};
      nxt_row[c] = cur[c] ? survive[cnt] : birth[cnt];
    end
  end

  always_comb begin
    same = 1'b1;
    for (int r = 0; r < HEIGHT; r++) begin
      if (shadow[r] != grid[r]) same = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    bus.busy  = 1'b0;
    bus.done  = 1'b0;
    case (state)
      IDLE:   if (bus.start) state_nxt = (bus.gens == '0) ? DONE : STEP;
      STEP: begin
        bus.busy = 1'b1;
        if (row == LAST) state_nxt = COMMIT;
      end
      COMMIT: begin
        bus.busy  = 1'b1;
        state_nxt = (remaining == GEN_W'(1) || same) ? DONE : STEP;
      end
      DONE: begin
        bus.done  = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int r = 0; r < HEIGHT; r++) begin
        grid[r]   <= '0;
        shadow[r] <= '0;
      end
      row           <= '0;
      remaining     <= '0;
      birth         <= '0;
      survive       <= '0;
      bus.stable    <= 1'b0;
      bus.gen_count <= '0;
      bus.rd_data   <= '0;
    end else begin
      bus.rd_data <= ({1'b0, bus.rd_row} < ROWS) ? grid[bus.rd_row] : '0;
      case (state)
        IDLE: begin
          if (bus.clr) begin
            for (int r = 0; r < HEIGHT; r++) grid[r] <= '0;
            bus.gen_count <= '0;
            bus.stable    <= 1'b0;
          end else if (bus.wr_en && ({1'b0, bus.wr_row} < ROWS)) begin
            grid[bus.wr_row] <= bus.wr_data;
          end
          if (bus.start) begin
            birth     <= bus.birth_mask;
            survive   <= bus.survive_mask;
            remaining <= bus.gens;
            row       <= '0;
            // A zero-generation run leaves the previous stability verdict in place.
            if (bus.gens != '0) bus.stable <= 1'b0;
          end
        end
        STEP: begin
          shadow[row] <= nxt_row;
          row         <= row + 1'b1;
        end
        COMMIT: begin
          for (int r = 0; r < HEIGHT; r++) grid[r] <= shadow[r];
          bus.gen_count <= bus.gen_count + 1'b1;
          remaining     <= remaining - 1'b1;
          bus.stable    <= same;
          row           <= '0;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_life_grid_engine.sv
// Drives a toroidal and a dead-border engine with identical stimulus and checks both against a cell-level model.
module tb_life_grid_engine;
  localparam int W = 16, H = 16, GW = 16, RW = 4;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  life_grid_engine_if #(.WIDTH(W), .HEIGHT(H), .GEN_W(GW)) bw ();
  life_grid_engine_if #(.WIDTH(W), .HEIGHT(H), .GEN_W(GW)) bd ();

  assign bd.birth_mask   = bw.birth_mask;
  assign bd.survive_mask = bw.survive_mask;
  assign bd.wr_en        = bw.wr_en;
  assign bd.wr_row       = bw.wr_row;
  assign bd.wr_data      = bw.wr_data;
  assign bd.clr          = bw.clr;
  assign bd.rd_row       = bw.rd_row;
  assign bd.start        = bw.start;
  assign bd.gens         = bw.gens;

  life_grid_engine #(.WIDTH(W), .HEIGHT(H), .WRAP(1'b1), .GEN_W(GW)) dut_w (.clk(clk), .rst_n(rst_n), .bus(bw));
  life_grid_engine #(.WIDTH(W), .HEIGHT(H), .WRAP(1'b0), .GEN_W(GW)) dut_d (.clk(clk), .rst_n(rst_n), .bus(bd));

  // Model state: index 1 = toroidal engine, index 0 = dead-border engine.
  bit mg [2][H][W];
  int mgc [2];
  bit mst [2];
  logic [W-1:0] snap [H];

  typedef struct {
    int         pat;
    logic [8:0] b;
    logic [8:0] s;
    int         gens;
    int         exp_gc;
    bit         exp_st;
  } vec_t;
  vec_t vt [5];

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0h, want %0h", name, act, exp);
    end
  endtask

  function automatic logic [W-1:0] mrow(input int k, input int r);
    logic [W-1:0] v;
    for (int c = 0; c < W; c++) v[c] = mg[k][r][c];
    return v;
  endfunction

  task automatic model_step(input int k, input logic [8:0] b, input logic [8:0] s, output bit same);
    bit nx [H][W];
    int n, rr, cc;
    same = 1'b1;
    for (int r = 0; r < H; r++) begin
      for (int c = 0; c < W; c++) begin
        n = 0;
        for (int dr = -1; dr <= 1; dr++) begin
          for (int dc = -1; dc <= 1; dc++) begin
            rr = r + dr;
            cc = c + dc;
            if (!(dr == 0 && dc == 0)) begin
              if (k == 1) n += int'(mg[k][(rr + H) % H][(cc + W) % W]);
              else if (rr >= 0 && rr < H && cc >= 0 && cc < W) n += int'(mg[k][rr][cc]);
            end
          end
        end
        nx[r][c] = mg[k][r][c] ? s[n] : b[n];
      end
    end
    for (int r = 0; r < H; r++) begin
      for (int c = 0; c < W; c++) begin
        if (nx[r][c] != mg[k][r][c]) same = 1'b0;
        mg[k][r][c] = nx[r][c];
      end
    end
  endtask

  task automatic model_run(input int k, input int g, input logic [8:0] b, input logic [8:0] s, output int ran);
    bit same;
    ran = 0;
    if (g > 0) mst[k] = 1'b0;
    for (int i = 0; i < g; i++) begin
      model_step(k, b, s, same);
      ran++;
      mgc[k] = (mgc[k] + 1) % 65536;
      mst[k] = same;
      if (same) break;
    end
  endtask

  task automatic clear_model();
    for (int k = 0; k < 2; k++) begin
      for (int r = 0; r < H; r++) for (int c = 0; c < W; c++) mg[k][r][c] = 1'b0;
      mgc[k] = 0;
      mst[k] = 1'b0;
    end
  endtask

  task automatic set_cell(input int r, input int c);
    mg[0][r][c] = 1'b1;
    mg[1][r][c] = 1'b1;
  endtask

  task automatic set_pattern(input int pat);
    clear_model();
    case (pat)
      0: begin set_cell(7, 6); set_cell(7, 7); set_cell(7, 8); end
      1: begin set_cell(0, 1); set_cell(1, 2); set_cell(2, 0); set_cell(2, 1); set_cell(2, 2); end
      2: begin set_cell(5, 5); set_cell(5, 6); set_cell(6, 5); set_cell(6, 6); end
      3: begin set_cell(0, 0); set_cell(0, 1); set_cell(0, 2); end
      default: set_cell(8, 8);
    endcase
  endtask

  // Clears the engines and writes the model's (common) starting grid into both.
  task automatic load();
    @(negedge clk);
    bw.clr = 1'b1;
    @(negedge clk);
    bw.clr = 1'b0;
    for (int r = 0; r < H; r++) begin
      bw.wr_en   = 1'b1;
      bw.wr_row  = r[RW-1:0];
      bw.wr_data = mrow(1, r);
      snap[r]    = mrow(1, r);
      @(negedge clk);
    end
    bw.wr_en = 1'b0;
    for (int k = 0; k < 2; k++) begin
      mgc[k] = 0;
      mst[k] = 1'b0;
    end
  endtask

  task automatic rd(input int r, output logic [W-1:0] w, output logic [W-1:0] d);
    bw.rd_row = r[RW-1:0];
    @(posedge clk);
    #1;
    w = bw.rd_data;
    d = bd.rd_data;
  endtask

  task automatic check_grids(input string name);
    logic [W-1:0] w, d;
    int bad_w, bad_d;
    bad_w = 0;
    bad_d = 0;
    for (int r = 0; r < H; r++) begin
      rd(r, w, d);
      if (w != mrow(1, r)) bad_w++;
      if (d != mrow(0, r)) bad_d++;
    end
    check({name, " wrap grid rows differing"}, bad_w, 0);
    check({name, " dead grid rows differing"}, bad_d, 0);
  endtask

  task automatic run(input string name, input logic [8:0] b, input logic [8:0] s, input int g, input bit disturb);
    int ran [2];
    int busyc [2];
    int donec [2];
    int budget;
    for (int k = 0; k < 2; k++) begin
      model_run(k, g, b, s, ran[k]);
      busyc[k] = 0;
      donec[k] = -1;
    end
    @(negedge clk);
    bw.birth_mask   = b;
    bw.survive_mask = s;
    bw.gens         = g[GW-1:0];
    bw.start        = 1'b1;
    @(negedge clk);
    bw.start = 1'b0;
    budget = g * (H + 1) + 20;
    for (int cyc = 0; cyc < budget; cyc++) begin
      if (bw.busy) busyc[1]++;
      if (bd.busy) busyc[0]++;
      if (bw.done && donec[1] < 0) donec[1] = cyc;
      if (bd.done && donec[0] < 0) donec[0] = cyc;
      if (disturb) begin
        bw.wr_en   = (cyc == 5);
        bw.clr     = (cyc == 5);
        bw.start   = (cyc == 5);
        bw.wr_row  = '0;
        bw.wr_data = '1;
      end
      if (donec[0] >= 0 && donec[1] >= 0) break;
      @(negedge clk);
    end
    bw.wr_en = 1'b0;
    bw.clr   = 1'b0;
    bw.start = 1'b0;
    check({name, " wrap done cycle"}, donec[1], ran[1] * (H + 1));
    check({name, " dead done cycle"}, donec[0], ran[0] * (H + 1));
    check({name, " wrap busy cycles"}, busyc[1], ran[1] * (H + 1));
    check({name, " dead busy cycles"}, busyc[0], ran[0] * (H + 1));
    check({name, " wrap gen_count"}, bw.gen_count, mgc[1]);
    check({name, " dead gen_count"}, bd.gen_count, mgc[0]);
    check({name, " wrap stable"}, bw.stable, mst[1]);
    check({name, " dead stable"}, bd.stable, mst[0]);
    check_grids(name);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [W-1:0] w, d;
    string nm;
    bit any_done;

    vt[0] = '{0, 9'h008, 9'h00C, 1, 1, 1'b0};
    vt[1] = '{1, 9'h008, 9'h00C, 64, 64, 1'b0};
    vt[2] = '{2, 9'h008, 9'h00C, 100, 1, 1'b1};
    vt[3] = '{3, 9'h008, 9'h00C, 1, 1, 1'b0};
    vt[4] = '{4, 9'h002, 9'h000, 1, 1, 1'b0};

    bw.birth_mask   = '0;
    bw.survive_mask = '0;
    bw.wr_en        = 1'b0;
    bw.wr_row       = '0;
    bw.wr_data      = '0;
    bw.clr          = 1'b0;
    bw.rd_row       = '0;
    bw.start        = 1'b0;
    bw.gens         = '0;
    clear_model();

    #1 rst_n = 1'b0;
    #11;
    check("reset busy", {bw.busy, bd.busy}, 0);
    check("reset done", {bw.done, bd.done}, 0);
    check("reset stable", {bw.stable, bd.stable}, 0);
    check("reset gen_count", bw.gen_count | bd.gen_count, 0);
    check("reset rd_data", bw.rd_data | bd.rd_data, 0);
    @(negedge clk);
    rst_n = 1'b1;
    check_grids("reset");

    for (int i = 0; i < 5; i++) begin
      nm = $sformatf("vec%0d", i);
      set_pattern(vt[i].pat);
      load();
      run(nm, vt[i].b, vt[i].s, vt[i].gens, 1'b0);
      check({nm, " table gen_count"}, bw.gen_count, vt[i].exp_gc);
      check({nm, " table stable"}, bw.stable, vt[i].exp_st);
      case (vt[i].pat)
        0: begin
          for (int r = 6; r <= 8; r++) begin
            rd(r, w, d);
            check($sformatf("blinker row %0d", r), w, 16'h0080);
          end
        end
        1: begin
          for (int r = 0; r < H; r++) begin
            rd(r, w, d);
            check($sformatf("glider row %0d back home", r), w, snap[r]);
          end
        end
        2: run("zero gens after still life", 9'h008, 9'h00C, 0, 1'b0);
        3: begin
          rd(15, w, d);
          check("edge row15 wrap", w, 16'h0002);
          check("edge row15 dead", d, 16'h0000);
          rd(0, w, d);
          check("edge row0 wrap", w, 16'h0002);
          check("edge row0 dead", d, 16'h0002);
          rd(1, w, d);
          check("edge row1 wrap", w, 16'h0002);
          check("edge row1 dead", d, 16'h0002);
        end
        default: begin
          rd(7, w, d);
          check("seed row7", w, 16'h0380);
          rd(8, w, d);
          check("seed row8", w, 16'h0280);
          rd(9, w, d);
          check("seed row9", w, 16'h0380);
        end
      endcase
    end

    for (int i = 0; i < 6; i++) begin
      logic [8:0] b, s;
      clear_model();
      for (int r = 0; r < H; r++) begin
        for (int c = 0; c < W; c++) begin
          if ($urandom_range(0, 2) == 0) set_cell(r, c);
        end
      end
      if (i % 2 == 0) begin
        b = 9'h008;
        s = 9'h00C;
      end else begin
        b = 9'($urandom_range(0, 511));
        s = 9'($urandom_range(0, 511));
      end
      load();
      run($sformatf("rand%0d", i), b, s, $urandom_range(1, 5), (i % 2) == 1);
    end

    set_pattern(1);
    load();
    @(negedge clk);
    bw.birth_mask   = 9'h008;
    bw.survive_mask = 9'h00C;
    bw.gens         = 16'd5;
    bw.start        = 1'b1;
    @(negedge clk);
    bw.start = 1'b0;
    bw.rd_row = '0;
    repeat (20) @(negedge clk);
    check("abort run in progress", {bw.busy, bd.busy}, 2'b11);
    #2 rst_n = 1'b0;
    #1;
    check("abort busy", {bw.busy, bd.busy}, 0);
    check("abort done", {bw.done, bd.done}, 0);
    check("abort gen_count", bw.gen_count | bd.gen_count, 0);
    check("abort stable", {bw.stable, bd.stable}, 0);
    check("abort rd_data", bw.rd_data | bd.rd_data, 0);
    any_done = 1'b0;
    repeat (4) begin
      @(negedge clk);
      if (bw.done || bd.done) any_done = 1'b1;
    end
    rst_n = 1'b1;
    repeat (40) begin
      @(negedge clk);
      if (bw.done || bd.done || bw.busy || bd.busy) any_done = 1'b1;
    end
    check("no done or busy after abort", any_done, 0);
    clear_model();
    check_grids("after abort");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
